// File: rtl/regfile_port_arbiter_pkg.sv
// Shared constants for the register-file read-port arbiter.
// Defaults for address/data width and requester limits.
package regfile_port_arbiter_pkg;

  localparam int ADDRW_DEF = 5;
  localparam int WIDTH_DEF = 32;
  localparam int NREQ_MAX  = 8;
  localparam int NREGS     = 32;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request
// at or after ptr, wrapping; one-hot grant plus binary index.
module regfile_port_arbiter_rr_pick
  import regfile_port_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDXW = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDXW-1:0] ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDXW-1:0] idx_o
);

  logic found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    // Pass 1 scans ptr..NREQ-1; pass 2 wraps to 0..ptr-1.
    for (int j = 0; j < NREQ; j++) begin
      if (en_i && !found && req_i[j] && (IDXW'(j) >= ptr_i)) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IDXW'(j);
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (en_i && !found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IDXW'(j);
      end
    end
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Round-robin sharing of one register-file read port; responses
// return tagged to the winner two cycles after acceptance.
module regfile_port_arbiter
  import regfile_port_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int ADDRW = ADDRW_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*ADDRW-1:0] req_addr,
  input  logic                  stall,
  output logic [NREQ-1:0]       grant,
  output logic [ADDRW-1:0]      rd_addr,
  input  logic [WIDTH-1:0]      rd_data,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_data
);

  localparam int IDXW = idx_w(NREQ);

  logic [IDXW-1:0]  ptr_q, ptr_d;
  logic             s1_valid_q, s1_valid_d;
  logic [IDXW-1:0]  s1_owner_q, s1_owner_d;
  logic [ADDRW-1:0] rd_addr_q, rd_addr_d;
  logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic [IDXW-1:0]  win;
  logic             acc;

  regfile_port_arbiter_rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .en_i  (~stall),
    .gnt_o (grant),
    .idx_o (win)
  );

  assign acc = |(req & grant);

  always_comb begin
    ptr_d       = ptr_q;
    s1_valid_d  = acc;
    s1_owner_d  = s1_owner_q;
    rd_addr_d   = rd_addr_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (acc) begin
      ptr_d      = (win == IDXW'(NREQ - 1)) ? '0 : win + 1'b1;
      s1_owner_d = win;
      rd_addr_d  = req_addr[win*ADDRW +: ADDRW];
    end
    // rsp_data holds its value between responses.
    if (s1_valid_q) begin
      rsp_valid_d[s1_owner_q] = 1'b1;
      rsp_data_d              = rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_owner_q  <= '0;
      rd_addr_q   <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      s1_valid_q  <= s1_valid_d;
      s1_owner_q  <= s1_owner_d;
      rd_addr_q   <= rd_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rd_addr   = rd_addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule
